// File: rtl/eth_mac_swap_64.sv
// Ethernet MAC swap: turns each received frame around to its sender with LOCAL_MAC as
// the source, optionally dropping frames not addressed to us. Payload passes straight through.
module eth_mac_swap_64 #(
  parameter logic [47:0] LOCAL_MAC     = 48'h02_00_00_00_00_00,
  parameter bit          ENABLE_FILTER = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_eth_hdr_valid,
  output logic        input_eth_hdr_ready,
  input  logic [47:0] input_eth_dest_mac,
  input  logic [47:0] input_eth_src_mac,
  input  logic [15:0] input_eth_type,
  input  logic [63:0] input_eth_payload_tdata,
  input  logic [7:0]  input_eth_payload_tkeep,
  input  logic        input_eth_payload_tvalid,
  output logic        input_eth_payload_tready,
  input  logic        input_eth_payload_tlast,
  input  logic        input_eth_payload_tuser,
  output logic        output_eth_hdr_valid,
  input  logic        output_eth_hdr_ready,
  output logic [47:0] output_eth_dest_mac,
  output logic [47:0] output_eth_src_mac,
  output logic [15:0] output_eth_type,
  output logic [63:0] output_eth_payload_tdata,
  output logic [7:0]  output_eth_payload_tkeep,
  output logic        output_eth_payload_tvalid,
  input  logic        output_eth_payload_tready,
  output logic        output_eth_payload_tlast,
  output logic        output_eth_payload_tuser,
  output logic        busy,
  output logic [31:0] frame_fwd_count,
  output logic [31:0] frame_drop_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, FORWARD = 2'd1, DROP = 2'd2} state_t;

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] eth_type;
  } eth_hdr_t;

  state_t   state;
  eth_hdr_t out_hdr;
  logic     hdr_hs, match, last_hs, fwd_act, drop_act;

  assign match = !ENABLE_FILTER || (input_eth_dest_mac == LOCAL_MAC) ||
                 (input_eth_dest_mac == 48'hFFFF_FFFF_FFFF);

  // Everything the handshakes depend on is gated by rst so reset quiets the ports at once.
  assign fwd_act  = !rst && (state == FORWARD);
  assign drop_act = !rst && (state == DROP);

  assign input_eth_hdr_ready      = !rst && (state == IDLE) && !output_eth_hdr_valid;
  assign input_eth_payload_tready = (fwd_act && output_eth_payload_tready) || drop_act;
  assign output_eth_payload_tvalid = fwd_act && input_eth_payload_tvalid;
  assign output_eth_payload_tdata = input_eth_payload_tdata;
  assign output_eth_payload_tkeep = input_eth_payload_tkeep;
  assign output_eth_payload_tlast = input_eth_payload_tlast;
  assign output_eth_payload_tuser = input_eth_payload_tuser;
  assign busy = !rst && (state != IDLE);

  assign hdr_hs  = input_eth_hdr_valid && input_eth_hdr_ready;
  assign last_hs = input_eth_payload_tvalid && input_eth_payload_tready && input_eth_payload_tlast;

  assign output_eth_dest_mac = out_hdr.dest;
  assign output_eth_src_mac  = out_hdr.src;
  assign output_eth_type     = out_hdr.eth_type;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      out_hdr              <= '0;
      output_eth_hdr_valid <= 1'b0;
      frame_fwd_count      <= '0;
      frame_drop_count     <= '0;
    end else begin
      if (output_eth_hdr_valid && output_eth_hdr_ready)
        output_eth_hdr_valid <= 1'b0;
      case (state)
        IDLE: if (hdr_hs) begin
          if (match) begin
            out_hdr              <= '{dest: input_eth_src_mac, src: LOCAL_MAC,
                                      eth_type: input_eth_type};
            output_eth_hdr_valid <= 1'b1;
            state                <= FORWARD;
          end else begin
            state <= DROP;
          end
        end
        FORWARD: if (last_hs) begin
          frame_fwd_count <= frame_fwd_count + 32'd1;
          state           <= IDLE;
        end
        DROP: if (last_hs) begin
          frame_drop_count <= frame_drop_count + 32'd1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
